two_b: RTL and testbench

- Four-input Boolean function block. Output f is the sum-of-minterms f(A,B,C,D) = Σm(1,3,5,6,7,8,14,15), with A as the MSB.
- Minimal SOP: f = A'·D + B·C + A·B'·C'·D'.
- Provides the combinational result plus a registered copy with valid qualification.
- Provides a minterm-coverage tracker so exhaustive truth-table sweeps can be self-checked in system and lab benches.

---
 rtl/two_b_pkg.sv | 13 +
 rtl/two_b_cov.sv | 39 +++
 rtl/two_b.sv | 56 +++++
 tb/tb_two_b.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/two_b_pkg.sv
// Shared constants and the truth-table lookup for the two_b four-input function block.
package two_b_pkg;

  localparam logic [15:0] TWO_B_DEFAULT_TT = 16'hC1EA;
  localparam int          IDX_W            = 4;
  localparam int          NUM_MT           = 1 << IDX_W;

  function automatic logic tt_lookup(input logic [NUM_MT-1:0] tt,
                                     input logic [IDX_W-1:0]  idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/two_b_cov.sv
// Minterm coverage tracker: sticky per-minterm seen bits plus a registered all-seen flag.
module two_b_cov
  import two_b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  idx,
  output logic [NUM_MT-1:0] seen,
  output logic              all_seen
);

  logic [NUM_MT-1:0] hit_p0;
  logic [NUM_MT-1:0] seen_nxt_p0;
  logic [NUM_MT-1:0] seen_p1;
  logic              all_p1;

  // Stage p0: fold the incoming sample into the coverage map before it is registered,
  // so all_seen rises on the same edge that records the final minterm.
  always_comb begin
    hit_p0      = in_valid ? (NUM_MT'(1) << idx) : '0;
    seen_nxt_p0 = seen_p1 | hit_p0;
  end

  // Stage p1
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_p1 <= '0;
      all_p1  <= 1'b0;
    end else begin
      seen_p1 <= seen_nxt_p0;
      all_p1  <= &seen_nxt_p0;
    end
  end

  assign seen     = seen_p1;
  assign all_seen = all_p1;

endmodule

// File: rtl/two_b.sv
// Four-input Boolean function f = TRUTH_TABLE[{A,B,C,D}] with a registered, valid-qualified copy.
module two_b
  import two_b_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TWO_B_DEFAULT_TT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        in_valid,
  output logic        f,
  output logic        f_q,
  output logic        out_valid,
  output logic [15:0] seen,
  output logic        all_seen
);

  logic [IDX_W-1:0] idx_p0;
  logic             f_p0;
  logic             f_p1;
  logic             vld_p1;

  // Stage p0: pure lookup, no clock or valid dependence.
  always_comb begin
    idx_p0 = {A, B, C, D};
    f_p0   = tt_lookup(TRUTH_TABLE, idx_p0);
  end

  // Stage p1: f_q follows f every cycle; out_valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_p1   <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      f_p1   <= f_p0;
      vld_p1 <= in_valid;
    end
  end

  two_b_cov u_cov (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .idx      (idx_p0),
    .seen     (seen),
    .all_seen (all_seen)
  );

  assign f         = f_p0;
  assign f_q       = f_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_two_b.sv
// Randomized self-checking bench for two_b against a sum-of-products / coverage-set reference model.
module tb_two_b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic        in_valid = 1'b0;
  logic        f, f_q, out_valid, all_seen;
  logic [15:0] seen;
  logic        f2, f_q2, out_valid2, all_seen2;
  logic [15:0] seen2;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic m_fq, m_ov, m_all;
  bit   m_hit [16];

  always #5 clk = ~clk;

  two_b u_dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .in_valid(in_valid),
    .f(f), .f_q(f_q), .out_valid(out_valid), .seen(seen), .all_seen(all_seen)
  );

  two_b #(.TRUTH_TABLE(16'h8001)) u_dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .in_valid(in_valid),
    .f(f2), .f_q(f_q2), .out_valid(out_valid2), .seen(seen2), .all_seen(all_seen2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_f(input int idx);
    logic a, b, c, d;
    {a, b, c, d} = 4'(idx);
    return (!a && d) || (b && c) || (a && !b && !c && !d);
  endfunction

  function automatic logic ref_f2(input int idx);
    return (idx == 0) || (idx == 15);
  endfunction

  function automatic logic [15:0] ref_seen();
    logic [15:0] s = '0;
    for (int i = 0; i < 16; i++) s[i] = m_hit[i];
    return s;
  endfunction

  function automatic int ref_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_hit[i]);
    return n;
  endfunction

  task automatic set_in(input int idx, input logic vld, input logic r);
    {A, B, C, D} = 4'(idx);
    in_valid = vld;
    rst = r;
  endtask

  // one clocked vector: drive mid-cycle, check f, clock it, check registered state
  task automatic step(input int idx, input logic vld, input logic r);
    @(negedge clk);
    set_in(idx, vld, r);
    #1;
    chk("f", 16'(f), 16'(ref_f(idx)));
    chk("f_tt8001", 16'(f2), 16'(ref_f2(idx)));
    @(posedge clk);
    if (r) begin
      m_fq = 1'b0; m_ov = 1'b0; m_all = 1'b0;
      for (int i = 0; i < 16; i++) m_hit[i] = 1'b0;
    end else begin
      m_fq = ref_f(idx);
      m_ov = vld;
      if (vld) m_hit[idx] = 1'b1;
      m_all = (ref_count() == 16);
    end
    #1;
    chk("f_q", 16'(f_q), 16'(m_fq));
    chk("out_valid", 16'(out_valid), 16'(m_ov));
    chk("seen", seen, ref_seen());
    chk("all_seen", 16'(all_seen), 16'(m_all));
    chk("f_after_edge", 16'(f), 16'(ref_f(idx)));
  endtask

  initial begin
    int golden [16] = '{0,1,0,1,0,1,1,1,1,0,0,0,0,0,1,1};

    // free-running combinational sweep, vectors every 20 ns
    for (int i = 0; i < 16; i++) begin
      set_in(i, 1'b0, 1'b0);
      #1;
      chk("sweep_f", 16'(f), 16'(golden[i]));
      chk("sweep_f_model", 16'(f), 16'(ref_f(i)));
      chk("sweep_f_tt8001", 16'(f2), 16'((i == 0 || i == 15) ? 1 : 0));
      #19;
    end

    // reset state
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("rst_seen", seen, 16'h0000);
    chk("rst_all", 16'(all_seen), 16'h0);

    // registered latency
    step(3, 1'b1, 1'b0);
    chk("lat_fq", 16'(f_q), 16'h1);
    chk("lat_ov", 16'(out_valid), 16'h1);
    step(4, 1'b0, 1'b0);
    chk("lat_fq_off", 16'(f_q), 16'h0);
    chk("lat_ov_off", 16'(out_valid), 16'h0);

    // partial coverage with duplicates
    step(0, 1'b0, 1'b1);
    step(5, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    step(10, 1'b1, 1'b0);
    chk("dup_seen", seen, 16'h0420);
    chk("dup_all", 16'(all_seen), 16'h0);

    // reset priority mid-sweep
    step(0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(i, 1'b1, 1'b0);
    chk("mid_seen", seen, 16'h00FF);
    step(9, 1'b1, 1'b1);
    chk("rstpri_seen", seen, 16'h0000);
    chk("rstpri_fq", 16'(f_q), 16'h0);
    chk("rstpri_ov", 16'(out_valid), 16'h0);
    chk("rstpri_f", 16'(f), 16'h0);

    // complete coverage
    for (int i = 0; i < 16; i++) begin
      step(i, 1'b1, 1'b0);
      chk("cov_all", 16'(all_seen), 16'((i == 15) ? 1 : 0));
    end
    chk("cov_seen", seen, 16'hFFFF);
    step(2, 1'b0, 1'b0);
    chk("cov_sticky", 16'(all_seen), 16'h1);

    // randomized traffic with occasional reset
    step(0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++)
      step($urandom_range(15), ($urandom_range(3) != 0), ($urandom_range(39) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
